// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - FU completion requests and dual-lane CDB bundle for cdb_arbiter
interface cdb_arbiter_if #(
   parameter int NUM_FU  = 4,
   parameter int PR_BITS = 6
);
   logic [NUM_FU-1:0]         fu_valid;
   logic [NUM_FU*PR_BITS-1:0] fu_prn;
   logic [NUM_FU*64-1:0]      fu_result;
   logic [NUM_FU-1:0]         fu_thread;
   logic [NUM_FU-1:0]         fu_ready;

   logic                      cdb0_valid;
   logic [PR_BITS-1:0]        cdb0_prn;
   logic [63:0]               cdb0_result;
   logic                      cdb0_thread;

   logic                      cdb1_valid;
   logic [PR_BITS-1:0]        cdb1_prn;
   logic [63:0]               cdb1_result;
   logic                      cdb1_thread;

   modport master (
      output fu_valid, fu_prn, fu_result, fu_thread,
      input  fu_ready,
      input  cdb0_valid, cdb0_prn, cdb0_result, cdb0_thread,
      input  cdb1_valid, cdb1_prn, cdb1_result, cdb1_thread
   );

   modport slave (
      input  fu_valid, fu_prn, fu_result, fu_thread,
      output fu_ready,
      output cdb0_valid, cdb0_prn, cdb0_result, cdb0_thread,
      output cdb1_valid, cdb1_prn, cdb1_result, cdb1_thread
   );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-FU result buffers with thread squash, round-robin onto two CDB lanes
module cdb_arbiter #(
   parameter int NUM_FU  = 4,
   parameter int QDEPTH  = 2,
   parameter int PR_BITS = 6
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         mispredict_thread_0,
   input  logic         mispredict_thread_1,
   cdb_arbiter_if.slave bus
);
   localparam int CW = $clog2(QDEPTH + 1);
   localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   typedef struct packed {
      logic [PR_BITS-1:0] prn;
      logic [63:0]        result;
      logic               thread;
   } entry_t;

   entry_t        buf_q   [NUM_FU][QDEPTH];
   logic [CW-1:0] cnt_q   [NUM_FU];
   logic [PW-1:0] rr_ptr;

   entry_t        in_ent  [NUM_FU];
   entry_t        sq_buf  [NUM_FU][QDEPTH];
   logic [CW-1:0] sq_cnt  [NUM_FU];
   entry_t        nxt_buf [NUM_FU][QDEPTH];
   logic [CW-1:0] nxt_cnt [NUM_FU];
   logic          g0_vld, g1_vld;
   logic [PW-1:0] g0_idx, g1_idx, nxt_rr;
   logic [1:0]    kill;

   assign kill = {mispredict_thread_1, mispredict_thread_0};

   always_comb begin
      bus.fu_ready = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         bus.fu_ready[i] = (cnt_q[i] < CW'(QDEPTH));
         in_ent[i] = {bus.fu_prn[i*PR_BITS +: PR_BITS], bus.fu_result[i*64 +: 64], bus.fu_thread[i]};
      end
   end

   // Compact surviving entries to the front so relative order is kept.
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         sq_cnt[i] = '0;
         for (int j = 0; j < QDEPTH; j++) begin
            sq_buf[i][j] = '0;
         end
         for (int j = 0; j < QDEPTH; j++) begin
            if (CW'(j) < cnt_q[i] && !kill[buf_q[i][j].thread]) begin
               sq_buf[i][sq_cnt[i]] = buf_q[i][j];
               sq_cnt[i] = sq_cnt[i] + CW'(1);
            end
         end
      end
   end

   always_comb begin
      int idx;
      idx    = 0;
      g0_vld = 1'b0;
      g1_vld = 1'b0;
      g0_idx = '0;
      g1_idx = '0;
      nxt_rr = rr_ptr;
      for (int k = 0; k < NUM_FU; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_FU;
         if (sq_cnt[idx] != '0) begin
            if (!g0_vld) begin
               g0_vld = 1'b1;
               g0_idx = PW'(idx);
            end else if (!g1_vld) begin
               g1_vld = 1'b1;
               g1_idx = PW'(idx);
            end
         end
      end
      if (g1_vld) begin
         nxt_rr = (g1_idx == PW'(NUM_FU - 1)) ? '0 : g1_idx + PW'(1);
      end else if (g0_vld) begin
         nxt_rr = (g0_idx == PW'(NUM_FU - 1)) ? '0 : g0_idx + PW'(1);
      end
   end

   // Pop precedes push so a full-then-popped buffer never overflows.
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         for (int j = 0; j < QDEPTH; j++) begin
            nxt_buf[i][j] = sq_buf[i][j];
         end
         nxt_cnt[i] = sq_cnt[i];
         if ((g0_vld && g0_idx == PW'(i)) || (g1_vld && g1_idx == PW'(i))) begin
            for (int j = 0; j < QDEPTH - 1; j++) begin
               nxt_buf[i][j] = sq_buf[i][j+1];
            end
            nxt_buf[i][QDEPTH-1] = '0;
            nxt_cnt[i] = sq_cnt[i] - CW'(1);
         end
         if (bus.fu_valid[i] && bus.fu_ready[i] && !kill[in_ent[i].thread]) begin
            nxt_buf[i][nxt_cnt[i]] = in_ent[i];
            nxt_cnt[i] = nxt_cnt[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_FU; i++) begin
            cnt_q[i] <= '0;
            for (int j = 0; j < QDEPTH; j++) begin
               buf_q[i][j] <= '0;
            end
         end
         rr_ptr          <= '0;
         bus.cdb0_valid  <= 1'b0;
         bus.cdb0_prn    <= '0;
         bus.cdb0_result <= '0;
         bus.cdb0_thread <= 1'b0;
         bus.cdb1_valid  <= 1'b0;
         bus.cdb1_prn    <= '0;
         bus.cdb1_result <= '0;
         bus.cdb1_thread <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            cnt_q[i] <= nxt_cnt[i];
            for (int j = 0; j < QDEPTH; j++) begin
               buf_q[i][j] <= nxt_buf[i][j];
            end
         end
         rr_ptr         <= nxt_rr;
         bus.cdb0_valid <= g0_vld;
         bus.cdb1_valid <= g1_vld;
         {bus.cdb0_prn, bus.cdb0_result, bus.cdb0_thread} <= g0_vld ? sq_buf[g0_idx][0] : '0;
         {bus.cdb1_prn, bus.cdb1_result, bus.cdb1_thread} <= g1_vld ? sq_buf[g1_idx][0] : '0;
      end
   end
endmodule
